// File: rtl/lane_spawner.sv
// lane_spawner
// Turns a serial random-bit stream into lane picks (0..2) for obstacle
// spawning. Two consecutive bits form a pick, MSB first. A pick of 3 is
// thrown away and counted, and collection starts over. An accepted pick is
// held until the spawn period comes due, then it is written into a small
// FIFO. Game logic drains the FIFO through a valid/ready handshake.
//
// Ports:
//   clk         system clock, all logic on posedge
//   rst         synchronous active-high reset
//   rand_bit    serial random bit, sampled every clock while collecting
//   tick        one-cycle game-step strobe that drives the spawn period
//   lane_ready  consumer accepts the head entry this cycle
//   lane_valid  FIFO holds at least one entry
//   lane        head lane (0..2), 0 while the FIFO is empty
//   reject_cnt  saturating count of discarded picks
//   missed      sticky flag: a spawn came due while one was still pending
module lane_spawner #(
  parameter int SPAWN_PERIOD = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rand_bit,
  input  logic       tick,
  input  logic       lane_ready,
  output logic       lane_valid,
  output logic [1:0] lane,
  output logic [7:0] reject_cnt,
  output logic       missed
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PER_W = $clog2(SPAWN_PERIOD);

  typedef enum logic {
    COLLECT,
    HOLD
  } state_t;

  state_t             state_q, state_d;
  logic               bitCnt_q, bitCnt_d;
  logic               sr_q, sr_d;
  logic [1:0]         cand_q, cand_d;
  logic [PER_W-1:0]   periodCnt_q, periodCnt_d;
  logic               due_q, due_d;
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [7:0]         rejectCnt_q, rejectCnt_d;
  logic               missed_q, missed_d;
  logic [1:0]         mem_q [FIFO_DEPTH];

  logic       pop;
  logic       full;
  logic       wrap;
  logic       pushOk;
  logic [1:0] pickValue;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop       = (count_q != '0) & lane_ready;
  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign wrap      = tick & (periodCnt_q == PER_W'(SPAWN_PERIOD - 1));
  assign pushOk    = (state_q == HOLD) & due_q & (~full | pop);
  assign pickValue = {sr_q, rand_bit};

  // Pick assembly and hold. The shift bit and bit counter only move while
  // collecting; bits arriving during HOLD are ignored.
  always_comb begin
    state_d     = state_q;
    bitCnt_d    = bitCnt_q;
    sr_d        = sr_q;
    cand_d      = cand_q;
    rejectCnt_d = rejectCnt_q;
    case (state_q)
      COLLECT: begin
        sr_d     = rand_bit;
        bitCnt_d = ~bitCnt_q;
        if (bitCnt_q) begin
          if (pickValue == 2'd3) begin
            if (rejectCnt_q != 8'hFF) begin
              rejectCnt_d = rejectCnt_q + 8'd1;
            end
          end else begin
            cand_d  = pickValue;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (pushOk) begin
          state_d  = COLLECT;
          bitCnt_d = 1'b0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Spawn period. A wrap in the same cycle as a push re-arms due, so the
  // next held pick is released on the following opportunity.
  always_comb begin
    periodCnt_d = periodCnt_q;
    due_d       = due_q;
    missed_d    = missed_q | (wrap & due_q & ~pushOk);
    if (tick) begin
      periodCnt_d = wrap ? '0 : periodCnt_q + PER_W'(1);
    end
    if (pushOk) begin
      due_d = 1'b0;
    end
    if (wrap) begin
      due_d = 1'b1;
    end
  end

  // FIFO bookkeeping. Pointers are power-of-two wide so they wrap by overflow.
  always_comb begin
    wrPtr_d = wrPtr_q + PTR_W'(pushOk);
    rdPtr_d = rdPtr_q + PTR_W'(pop);
    count_d = count_q + CNT_W'(pushOk) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      bitCnt_q    <= 1'b0;
      sr_q        <= 1'b0;
      cand_q      <= 2'd0;
      periodCnt_q <= '0;
      due_q       <= 1'b0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      rejectCnt_q <= 8'd0;
      missed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      sr_q        <= sr_d;
      cand_q      <= cand_d;
      periodCnt_q <= periodCnt_d;
      due_q       <= due_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      rejectCnt_q <= rejectCnt_d;
      missed_q    <= missed_d;
    end
  end

  // Storage is not reset; the lane output is masked to 0 while empty.
  always_ff @(posedge clk) begin
    if (pushOk && !rst) begin
      mem_q[wrPtr_q] <= cand_q;
    end
  end

  assign lane_valid = (count_q != '0);
  assign lane       = lane_valid ? mem_q[rdPtr_q] : 2'd0;
  assign reject_cnt = rejectCnt_q;
  assign missed     = missed_q;

endmodule

// File: tb/tb_lane_spawner.sv
// Testbench for lane_spawner (SPAWN_PERIOD=4, FIFO_DEPTH=4).
// Stimulus drives inputs on the falling edge and advances a behavioural
// model after the rising edge; every spawn the model predicts is queued as
// an expected lane. A monitor compares outputs each cycle and pops the
// expected queue on every handshake.
module tb_lane_spawner;

  localparam int P = 4;
  localparam int D = 4;

  logic       clk;
  logic       rst;
  logic       randBit;
  logic       tick;
  logic       laneReady;
  logic       laneValid;
  logic [1:0] lane;
  logic [7:0] rejectCnt;
  logic       missed;

  int checks   = 0;
  int failures = 0;
  bit monitorOn = 0;

  // Behavioural model state
  bit collecting = 1;
  bit haveFirst  = 0;
  int firstBit   = 0;
  int cand       = 0;
  int ticks      = 0;
  bit due        = 0;
  int rejects    = 0;
  bit missedM    = 0;
  int fifoM[$];
  int expQ[$];

  lane_spawner #(.SPAWN_PERIOD(P), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .rand_bit   (randBit),
    .tick       (tick),
    .lane_ready (laneReady),
    .lane_valid (laneValid),
    .lane       (lane),
    .reject_cnt (rejectCnt),
    .missed     (missed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // One clock of the reference behaviour, written from the rules:
  // pairs of bits make a pick, 3 is rejected, one pick per period enters
  // a bounded queue, overdue periods set missed.
  task automatic modelStep(input bit r, input bit rb, input bit tk, input bit rdy);
    bit popNow, wrapNow, pushNow;
    int v;
    if (r) begin
      collecting = 1; haveFirst = 0; firstBit = 0; cand = 0;
      ticks = 0; due = 0; rejects = 0; missedM = 0;
      fifoM.delete();
      expQ.delete();
      return;
    end
    popNow  = (fifoM.size() > 0) && rdy;
    wrapNow = tk && (ticks == P - 1);
    pushNow = !collecting && due && ((fifoM.size() < D) || popNow);
    if (popNow) void'(fifoM.pop_front());
    if (pushNow) begin
      fifoM.push_back(cand);
      expQ.push_back(cand);
      collecting = 1;
      haveFirst  = 0;
    end else if (collecting) begin
      if (!haveFirst) begin
        firstBit  = rb;
        haveFirst = 1;
      end else begin
        v = firstBit * 2 + rb;
        haveFirst = 0;
        if (v == 3) begin
          if (rejects < 255) rejects++;
        end else begin
          cand = v;
          collecting = 0;
        end
      end
    end
    if (wrapNow && due && !pushNow) missedM = 1;
    if (pushNow) due = 0;
    if (wrapNow) due = 1;
    if (tk) ticks = (ticks + 1) % P;
  endtask

  task automatic applyStimulus(input bit r, input bit rb, input bit tk, input bit rdy);
    @(negedge clk);
    rst       = r;
    randBit   = rb;
    tick      = tk;
    laneReady = rdy;
    @(posedge clk);
    #1;
    modelStep(r, rb, tk, rdy);
  endtask

  // Monitor: per-cycle state comparison plus scoreboard pop on handshake.
  always @(negedge clk) begin
    if (monitorOn) begin
      #1;
      checkOutput("lane_valid", int'(laneValid), int'(fifoM.size() > 0));
      checkOutput("reject_cnt", int'(rejectCnt), rejects);
      checkOutput("missed", int'(missed), int'(missedM));
      if (!laneValid) checkOutput("lane_empty_zero", int'(lane), 0);
      else checkOutput("lane_not_3", int'(lane != 2'd3), 1);
      if (laneValid && laneReady && !rst) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_pop_lane", int'(lane), -1);
        end else begin
          checkOutput("lane_pop", int'(lane), expQ.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1; randBit = 1'b0; tick = 1'b0; laneReady = 1'b0;

    // First spawn latency: pick 01 -> lane 1, visible in cycle 5
    applyStimulus(1, 0, 1, 0);
    monitorOn = 1;
    checkOutput("reset_valid", int'(laneValid), 0);
    checkOutput("reset_reject", int'(rejectCnt), 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("no_valid_before_push", int'(laneValid), 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("first_valid_cycle5", int'(laneValid), 1);
    checkOutput("first_lane_cycle5", int'(lane), 1);

    // Rejections 11,11 then 10 -> lane 2
    applyStimulus(1, 0, 1, 1);
    applyStimulus(0, 1, 1, 1);
    applyStimulus(0, 1, 1, 1);
    applyStimulus(0, 1, 1, 1);
    applyStimulus(0, 1, 1, 1);
    applyStimulus(0, 1, 1, 1);
    applyStimulus(0, 0, 1, 1);
    checkOutput("two_rejects", int'(rejectCnt), 2);
    begin
      bit seen = 0;
      for (int i = 0; i < 12 && !seen; i++) begin
        applyStimulus(0, 0, 1, 1);
        if (laneValid) begin
          seen = 1;
          checkOutput("first_entry_lane2", int'(lane), 2);
        end
      end
      if (!seen) checkOutput("first_entry_timeout", 0, 1);
    end

    // Fill the FIFO with no consumer, then one pop with a same-cycle push
    applyStimulus(1, 0, 1, 0);
    for (int i = 0; i < 40; i++) applyStimulus(0, 0, 1, 0);
    checkOutput("full_valid", int'(laneValid), 1);
    checkOutput("full_missed", int'(missed), 1);
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 1, 0);
    checkOutput("still_valid_after_swap", int'(laneValid), 1);

    // Reject saturation, then reset clears everything
    applyStimulus(1, 1, 0, 1);
    for (int i = 0; i < 530; i++) applyStimulus(0, 1, 1'($urandom_range(0, 1)), 1);
    checkOutput("reject_saturated", int'(rejectCnt), 255);
    checkOutput("no_valid_all_rejects", int'(laneValid), 0);
    applyStimulus(1, 0, 1, 1);
    checkOutput("reset_clears_reject", int'(rejectCnt), 0);
    checkOutput("reset_clears_missed", int'(missed), 0);

    // Sparse ticks: every third clock
    for (int i = 0; i < 90; i++) applyStimulus(0, 1'($urandom_range(0, 1)), (i % 3) == 0, 1);

    // Randomised traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end

    @(negedge clk);
    #2;
    monitorOn = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
